// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
//   Bytes offered on the store path are queued in a small circular FIFO and
//   serialised LSB-first (start bit, 8 data bits, stop bit) at BAUDRATE.
// Ports:
//   clk        in   core clock, rising edge
//   rst        in   synchronous active-high reset
//   wr_valid   in   byte offered
//   wr_data    in   byte to transmit
//   wr_ready   out  FIFO not full (push = wr_valid & wr_ready)
//   tx_o       out  serial line, idle high (registered)
//   busy       out  frame in progress or bytes queued (registered)
//   fifo_count out  entries currently stored
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUDRATE    = 1_152_000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_valid,
    input  logic [7:0]                         wr_data,
    output logic                               wr_ready,
    output logic                               tx_o,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUDRATE;
    localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned BaudW      = $clog2(ClksPerBit);

    if (ClksPerBit < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ_HZ/BAUDRATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            push, pop, fifo_empty, bit_done;

    assign fifo_empty = (count_q == '0);
    assign wr_ready   = (count_q != CntW'(FIFO_DEPTH));
    assign push       = wr_valid & wr_ready;
    assign bit_done   = (baud_q == BaudW'(ClksPerBit - 1));

    assign tx_o       = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // tx_d is computed together with the next state so the line value always
    // lines up with the state's own cycles; a frame is exactly 10 bit periods.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_done) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_d];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (bit_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
        busy_d = !((state_d == StIdle) && (count_d == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo at 100 MHz / 1.152 Mbaud.
//   A line decoder turns tx_o back into bytes, frame start cycles and low-cycle
//   counts; scenario tasks compare those against a byte scoreboard and timing
//   figures derived from the 86-cycle bit period.
module tb_uart_tx_fifo;

    localparam int CPB   = 86;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, tx_o, busy;
    logic [3:0] fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ_HZ (100_000_000),
        .BAUDRATE    (1_152_000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx_o       (tx_o),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Scoreboard: bytes accepted, in order, and what the line decoder saw.
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         rx_ok[$];
    int         rx_start[$];
    int         rx_low[$];
    int         starts = 0;
    int         max_cnt = 0;
    int         ready_viol = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Line decoder: a frame is a start-low, 8 data, stop-high sequence of exactly
    // FRAME cycles, each bit constant over its CPB cycles.
    initial begin
        bit in_frame = 1'b0;
        int pos = 0;
        int lows = 0;
        bit ok = 1'b0;
        logic cur = 1'b1;
        logic [7:0] sh = 8'h00;
        forever begin
            @(negedge clk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (wr_ready !== (int'(fifo_count) != DEPTH)) ready_viol++;
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tx_o === 1'b0) begin
                    in_frame = 1'b1;
                    pos = 0; lows = 0; ok = 1'b1; sh = 8'h00;
                    starts++;
                    rx_start.push_back(cyc);
                end
                if (in_frame) begin
                    if (tx_o === 1'b0) lows++;
                    if (pos % CPB == 0) begin
                        cur = tx_o;
                        if (pos / CPB == 0 && cur !== 1'b0) ok = 1'b0;
                        if (pos / CPB == 9 && cur !== 1'b1) ok = 1'b0;
                        if (pos / CPB >= 1 && pos / CPB <= 8) sh[pos / CPB - 1] = cur;
                    end else if (tx_o !== cur) begin
                        ok = 1'b0;
                    end
                    pos++;
                    if (pos == FRAME) begin
                        rx_q.push_back(sh);
                        rx_ok.push_back(ok);
                        rx_low.push_back(lows);
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clear_sb();
        exp_q.delete(); rx_q.delete(); rx_ok.delete(); rx_start.delete(); rx_low.delete();
    endtask

    // Offer a byte and hold it until the edge that accepts it; acc = that edge's cycle.
    task automatic push(input logic [7:0] b, output int acc);
        bit r = 1'b0;
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (!r && n < 3000) begin
            @(negedge clk);
            r = wr_ready;
            tick();
            n++;
        end
        wr_valid = 1'b0;
        acc = cyc;
        if (r) begin
            exp_q.push_back(b);
        end else begin
            total++; bad++;
            $display("FAIL push_timeout: byte %02h not accepted after %0d cycles (required accepted)", b, n);
        end
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (rx_q.size() < n && k < n * FRAME + 3000) begin
            tick();
            k++;
        end
        if (rx_q.size() < n) begin
            total++; bad++;
            $display("FAIL frame_timeout: got %0d frames, required %0d", rx_q.size(), n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 30000) begin
            tick();
            k++;
        end
        if (busy !== 1'b0) begin
            total++; bad++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
        rst = 1'b0;
        repeat (5) tick();
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL idle_tx: got %b want 1", tx_o); end
    endtask

    task automatic test_single();
        int acc;
        clear_sb();
        push(8'h55, acc);
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL single_tx_pre: got %b want 1", tx_o); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        tick();
        total++; if (tx_o !== 1'b0) begin bad++; $display("FAIL single_fall: got %b want 0", tx_o); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL single_pop: got %0d want 0", fifo_count); end
        wait_until(acc + FRAME);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_end: got %b want 1", busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_low: got %b want 0", busy); end
        wait_frames(1);
        if (rx_q.size() >= 1) begin
            total++; if (rx_q[0] !== 8'h55) begin bad++; $display("FAIL single_byte: got %02h want 55", rx_q[0]); end
            total++; if (!rx_ok[0]) begin bad++; $display("FAIL single_frame: got malformed want 8N1"); end
            total++; if (rx_start[0] != acc + 1) begin bad++; $display("FAIL single_latency: got start %0d want %0d", rx_start[0], acc + 1); end
        end
    endtask

    task automatic test_back_to_back();
        int a0, a1;
        clear_sb();
        push(8'h48, a0);
        push(8'h69, a1);
        total++; if (a1 != a0 + 1) begin bad++; $display("FAIL b2b_push: got %0d want %0d", a1, a0 + 1); end
        wait_frames(2);
        if (rx_q.size() >= 2) begin
            total++; if (rx_q[0] !== 8'h48 || rx_q[1] !== 8'h69) begin bad++; $display("FAIL b2b_bytes: got %02h %02h want 48 69", rx_q[0], rx_q[1]); end
            total++; if (!rx_ok[0] || !rx_ok[1]) begin bad++; $display("FAIL b2b_frame: got %b%b want 11", rx_ok[0], rx_ok[1]); end
            total++; if (rx_start[1] - rx_start[0] != FRAME) begin bad++; $display("FAIL b2b_gap: got %0d want %0d", rx_start[1] - rx_start[0], FRAME); end
        end
        wait_idle();
    endtask

    task automatic test_full_stall();
        int acc[12];
        int want;
        clear_sb();
        max_cnt = 0;
        ready_viol = 0;
        for (int k = 0; k < 12; k++) push(8'($urandom), acc[k]);
        for (int k = 1; k < 12; k++) begin
            // Nine pushes fill the FIFO (one byte popped at once); later ones wait for each pop.
            want = (k <= 8) ? acc[0] + k : acc[0] + 2 + (k - 8) * FRAME;
            total++; if (acc[k] != want) begin bad++; $display("FAIL stall_accept[%0d]: got cycle %0d want %0d", k, acc[k], want); end
        end
        wait_frames(12);
        total++; if (max_cnt != DEPTH) begin bad++; $display("FAIL stall_maxcount: got %0d want %0d", max_cnt, DEPTH); end
        total++; if (ready_viol != 0) begin bad++; $display("FAIL stall_ready: got %0d bad cycles want 0", ready_viol); end
        for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin bad++; $display("FAIL stall_byte[%0d]: got %02h ok=%b want %02h", i, rx_q[i], rx_ok[i], exp_q[i]); end
            if (i > 0) begin
                total++; if (rx_start[i] - rx_start[i-1] != FRAME) begin bad++; $display("FAIL stall_gap[%0d]: got %0d want %0d", i, rx_start[i] - rx_start[i-1], FRAME); end
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int a, d, s, n0;
        logic [7:0] a5 = 8'hA5;
        logic [7:0] b;
        clear_sb();
        push(a5, a);
        push(8'($urandom), d);
        push(8'($urandom), d);
        s = a + 1;
        wait_until(s + 4 * CPB + 40);
        total++; if (tx_o !== a5[3]) begin bad++; $display("FAIL rst_bit3: got %b want %b", tx_o, a5[3]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b want 1", tx_o); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n0 = starts;
        repeat (2 * FRAME) tick();
        total++; if (starts != n0 || tx_o !== 1'b1) begin bad++; $display("FAIL rst_quiet: got %0d new starts tx=%b want 0 and 1", starts - n0, tx_o); end
        total++; if (rx_q.size() != 0) begin bad++; $display("FAIL rst_abort: got %0d frames want 0", rx_q.size()); end
        clear_sb();
        b = 8'($urandom);
        push(b, a);
        wait_frames(1);
        if (rx_q.size() >= 1) begin
            total++; if (rx_q[0] !== b || !rx_ok[0]) begin bad++; $display("FAIL rst_after: got %02h ok=%b want %02h", rx_q[0], rx_ok[0], b); end
        end
        wait_idle();
    endtask

    task automatic test_stop_push();
        int a, a2, s;
        logic [7:0] b1, b2;
        clear_sb();
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        push(b1, a);
        s = a + 1;
        wait_until(s + 9 * CPB + 20);
        push(b2, a2);
        total++; if (a2 != s + 9 * CPB + 21) begin bad++; $display("FAIL stop_accept: got %0d want %0d", a2, s + 9 * CPB + 21); end
        total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL stop_count: got %0d want 1", fifo_count); end
        wait_frames(2);
        if (rx_q.size() >= 2) begin
            total++; if (rx_q[0] !== b1 || rx_q[1] !== b2) begin bad++; $display("FAIL stop_bytes: got %02h %02h want %02h %02h", rx_q[0], rx_q[1], b1, b2); end
            total++; if (rx_start[1] != s + FRAME) begin bad++; $display("FAIL stop_gap: got %0d want %0d", rx_start[1], s + FRAME); end
        end
        wait_idle();
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL stop_drain: got %0d want 0", fifo_count); end
    endtask

    task automatic test_extremes();
        int a;
        clear_sb();
        push(8'h00, a);
        push(8'hFF, a);
        wait_frames(2);
        if (rx_q.size() >= 2) begin
            total++; if (rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF) begin bad++; $display("FAIL ext_bytes: got %02h %02h want 00 ff", rx_q[0], rx_q[1]); end
            total++; if (rx_low[0] != 9 * CPB) begin bad++; $display("FAIL ext_low00: got %0d low cycles want %0d", rx_low[0], 9 * CPB); end
            total++; if (rx_low[1] != CPB) begin bad++; $display("FAIL ext_lowff: got %0d low cycles want %0d", rx_low[1], CPB); end
        end
        wait_idle();
    endtask

    task automatic test_random();
        int a, gap;
        clear_sb();
        for (int k = 0; k < 16; k++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1500)) : 0;
            repeat (gap) tick();
            push(8'($urandom), a);
        end
        wait_frames(16);
        total++; if (rx_q.size() != 16) begin bad++; $display("FAIL rand_count: got %0d want 16", rx_q.size()); end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            total++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin bad++; $display("FAIL rand_byte[%0d]: got %02h ok=%b want %02h", i, rx_q[i], rx_ok[i], exp_q[i]); end
            if (i > 0) begin
                total++; if (rx_start[i] - rx_start[i-1] < FRAME) begin bad++; $display("FAIL rand_gap[%0d]: got %0d want >=%0d", i, rx_start[i] - rx_start[i-1], FRAME); end
            end
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_stall();
        test_reset_mid();
        test_stop_push();
        test_extremes();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
